// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the round-robin memory-port arbiter.
// Holds the FSM state enum, default parameter values and the grant index type.
package apb_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_TIMEOUT    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef logic [$clog2(DEF_NUM_REQ)-1:0] grant_idx_t;

endpackage

// File: rtl/apb_rr_picker.sv
// Round-robin picker: owns the last-grant pointer and selects the first
// pending requester searching upward from (last_grant+1) mod NUM_REQ.
// The pointer moves only when the FSM pulses update_en_i.
module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic                       update_en_i,
    input  logic [$clog2(NUM_REQ)-1:0] update_idx_i,
    output logic                       any_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
    output logic [NUM_REQ-1:0]         grant_onehot_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cand_idx;
    int unsigned      cand;
    logic             found;

    // Last-grant pointer; reset points at the top index so requester 0 wins first.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= IDX_W'(NUM_REQ - 1);
        end else if (update_en_i) begin
            last_q <= update_idx_i;
        end
    end

    // Rotating priority search starting just above the last grant.
    always_comb begin
        found          = 1'b0;
        cand           = 0;
        cand_idx       = '0;
        grant_idx_o    = '0;
        grant_onehot_o = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = int'(last_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req_valid_i[cand_idx]) begin
                found                    = 1'b1;
                grant_idx_o              = cand_idx;
                grant_onehot_o[cand_idx] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port among NUM_REQ
// requesters. Each grant becomes exactly one memory transaction; completion
// returns to the owner as a one-cycle req_ready_o pulse.
// Optional feature: APB_ARB_TIMEOUT_EN adds a wait-state limit (TIMEOUT cycles
// in ACCESS) that ends the transaction with req_err_o=1.
//
// Handshake semantics: a requester raises req_valid_i[i] with stable
// addr/wdata/wr_rd and holds it until it sees req_ready_o[i] for one cycle.
// On the memory side mem_valid_o rises with stable mem_* and stays high until
// the first posedge where mem_ready_i=1; that edge is the transfer.
module apb_mem_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [WIDTH-1:0]              req_rdata_o,
    output logic                          req_err_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [WIDTH-1:0]              mem_wdata_o,
    output logic                          mem_wr_rd_o,
    output logic                          mem_valid_o,
    input  logic [WIDTH-1:0]              mem_rdata_i,
    input  logic                          mem_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]    grant_o,
    output state_e                        state_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_e               state_q;
    state_e               state_d;
    logic                 load;
    logic                 finish;
    logic                 timeout_hit;
    logic                 pick_any;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [NUM_REQ-1:0]   owner_q;

    assign state_o = state_q;

    apb_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .update_en_i    (finish),
        .update_idx_i   (grant_o),
        .any_o          (pick_any),
        .grant_idx_o    (pick_idx),
        .grant_onehot_o (pick_onehot)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;

    // Cycles spent in ACCESS; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt_q <= '0;
        end else if (state_q == ACCESS) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    // Fires on the TIMEOUT-th ACCESS cycle; mem_ready_i still wins a tie.
    assign timeout_hit = (state_q == ACCESS) && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    // Error flag accompanies the ready pulse only when the limit ended the access.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_err_o <= 1'b0;
        end else begin
            req_err_o <= finish && !mem_ready_i;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign req_err_o   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the load/finish strobes that steer the datapath.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    load    = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready_i || timeout_hit) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side request registers, completion pulse and read data capture.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wr_rd_o <= 1'b0;
            mem_valid_o <= 1'b0;
            grant_o     <= '0;
            owner_q     <= '0;
            req_ready_o <= '0;
            req_rdata_o <= '0;
        end else begin
            req_ready_o <= '0;
            if (load) begin
                mem_addr_o  <= req_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata_o <= req_wdata_i[pick_idx*WIDTH +: WIDTH];
                mem_wr_rd_o <= req_wr_rd_i[pick_idx];
                mem_valid_o <= 1'b1;
                grant_o     <= pick_idx;
                owner_q     <= pick_onehot;
            end
            if (finish) begin
                mem_valid_o <= 1'b0;
                req_ready_o <= owner_q;
                if (mem_ready_i && !mem_wr_rd_o) begin
                    req_rdata_o <= mem_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Self-checking bench for apb_mem_arbiter. Define APB_ARB_TIMEOUT_EN to
// include the wait-state limit scenarios.
module tb_apb_mem_arbiter;
    import apb_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int AW      = 8;
    localparam int W       = 32;
    localparam int TIMEOUT = 16;
    localparam int EXP_W   = NUM_REQ + W + 1;
    localparam int MEM_W   = 1 + AW + W;

    // ---------------- clock / reset ----------------
    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b0;
    logic [NUM_REQ-1:0]    req_valid_i = '0;
    logic [NUM_REQ-1:0]    req_wr_rd_i = '0;
    logic [NUM_REQ*AW-1:0] req_addr_i  = '0;
    logic [NUM_REQ*W-1:0]  req_wdata_i = '0;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [W-1:0]          req_rdata_o;
    logic                  req_err_o;
    logic [AW-1:0]         mem_addr_o;
    logic [W-1:0]          mem_wdata_o;
    logic                  mem_wr_rd_o;
    logic                  mem_valid_o;
    logic [W-1:0]          mem_rdata_i = '0;
    logic                  mem_ready_i = 1'b0;
    logic [1:0]            grant_o;
    state_e                state_o;

    always #5 clk_i = ~clk_i;

    apb_mem_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (AW),
        .WIDTH      (W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_wr_rd_i (req_wr_rd_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .req_rdata_o (req_rdata_o),
        .req_err_o   (req_err_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wr_rd_o (mem_wr_rd_o),
        .mem_valid_o (mem_valid_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .grant_o     (grant_o),
        .state_o     (state_o)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [MEM_W-1:0] mem_exp_q[$];
    int               ready_cyc[$];
    int               remaining[NUM_REQ];
    int               wait_states = 0;
    int               ws_left = 0;
    int               model_last = NUM_REQ - 1;
    logic [W-1:0]     rdata_model = '0;

    function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // Expected completion for requester idx, pushed in the order it must finish.
    function automatic void push_exp(input int idx, input logic wr, input logic [AW-1:0] a,
                                     input logic [W-1:0] d, input logic err);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        if (!err) mem_exp_q.push_back({wr, a, d});
        if (!wr && !err) rdata_model = mem_word(a);
        exp_q.push_back({oh, rdata_model, err});
        model_last = idx;
    endfunction

    initial forever begin
        @(posedge clk_i);
        cycle++;
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int idx, input logic wr, input logic [AW-1:0] a,
                         input logic [W-1:0] d, input int count);
        req_wr_rd_i[idx]         = wr;
        req_addr_i[idx*AW +: AW] = a;
        req_wdata_i[idx*W +: W]  = d;
        remaining[idx]           = count;
        req_valid_i[idx]         = 1'b1;
    endtask

    // Requesters hold valid until their last ready pulse.
    initial forever begin
        @(negedge clk_i);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready_o[i] && remaining[i] > 0) remaining[i]--;
            req_valid_i[i] = (remaining[i] > 0);
        end
    end

    // Memory model with a programmable number of wait states.
    initial begin
        logic [MEM_W-1:0] m;
        forever begin
            @(negedge clk_i);
            if (mem_valid_o) begin
                if (ws_left == 0) begin
                    checks++;
                    if (mem_exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL mem_access: unexpected access wr=%0b addr=%h wdata=%h", mem_wr_rd_o, mem_addr_o, mem_wdata_o);
                    end else begin
                        m = mem_exp_q.pop_front();
                        if ({mem_wr_rd_o, mem_addr_o, mem_wdata_o} !== m) begin
                            errors++;
                            $display("FAIL mem_access: got wr/addr/wdata %h required %h", {mem_wr_rd_o, mem_addr_o, mem_wdata_o}, m);
                        end
                    end
                    mem_ready_i = 1'b1;
                    mem_rdata_i = mem_wr_rd_o ? W'($urandom) : mem_word(mem_addr_o);
                end else begin
                    ws_left--;
                    mem_ready_i = 1'b0;
                    mem_rdata_i = W'($urandom);
                end
            end else begin
                mem_ready_i = 1'b0;
                mem_rdata_i = W'($urandom);
                ws_left     = wait_states;
            end
        end
    end

    // Completion monitor: every ready pulse must match the head of exp_q.
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_i && req_ready_o != '0) begin
                checks++;
                ready_cyc.push_back(cycle);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL completion: unexpected ready=%b rdata=%h err=%b", req_ready_o, req_rdata_o, req_err_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({req_ready_o, req_rdata_o, req_err_o} !== e) begin
                        errors++;
                        $display("FAIL completion: got ready/rdata/err %h required %h", {req_ready_o, req_rdata_o, req_err_o}, e);
                    end
                end
            end
        end
    end

    function automatic bit pending();
        return (exp_q.size() != 0) || (mem_exp_q.size() != 0) || (req_valid_i != '0) || (state_o != IDLE);
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL %s drain: %0d completions outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
        end
    endtask

    task automatic wait_mem_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!mem_valid_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (!mem_valid_o) begin
            errors++;
            $display("FAIL %s start: mem_valid_o=0 after %0d cycles, required 1", name, budget);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
        req_valid_i = '0;
        exp_q.delete();
        mem_exp_q.delete();
        model_last  = NUM_REQ - 1;
        rdata_model = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_models();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_models();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({mem_valid_o, req_ready_o, req_err_o, mem_wr_rd_o, grant_o} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0", {mem_valid_o, req_ready_o, req_err_o, mem_wr_rd_o, grant_o});
        end
        checks++;
        if ({req_rdata_o, mem_addr_o, mem_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {req_rdata_o, mem_addr_o, mem_wdata_o});
        end
        checks++;
        if (state_o !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", state_o, IDLE);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_single_read();
        wait_states = 0;
        @(negedge clk_i);
        push_exp(0, 1'b0, 8'h10, 32'h0, 1'b0);
        issue(0, 1'b0, 8'h10, 32'h0, 1);
        @(negedge clk_i);
        checks++;
        if ({mem_valid_o, mem_addr_o, grant_o} !== {1'b1, 8'h10, 2'd0}) begin
            errors++;
            $display("FAIL single_cycle1: got valid/addr/grant %h required %h", {mem_valid_o, mem_addr_o, grant_o}, {1'b1, 8'h10, 2'd0});
        end
        @(negedge clk_i);
        checks++;
        if ({req_ready_o, req_rdata_o} !== {4'b0001, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_cycle2: got ready/rdata %h required %h", {req_ready_o, req_rdata_o}, {4'b0001, 32'hDEADBEEF});
        end
        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 4'b0000 || state_o !== IDLE || mem_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle3: got ready=%b state=%0d valid=%b required 0000/IDLE/0", req_ready_o, state_o, mem_valid_o);
        end
        wait_drain("single_read", 20);
    endtask

    task automatic test_round_robin();
        apply_reset();
        wait_states = 0;
        @(negedge clk_i);
        ready_cyc.delete();
        push_exp(0, 1'b0, 8'h20, 32'hA0, 1'b0);
        push_exp(1, 1'b1, 8'h21, 32'hA1, 1'b0);
        push_exp(2, 1'b0, 8'h22, 32'hA2, 1'b0);
        push_exp(3, 1'b1, 8'h23, 32'hA3, 1'b0);
        push_exp(0, 1'b0, 8'h20, 32'hA0, 1'b0);
        issue(0, 1'b0, 8'h20, 32'hA0, 2);
        issue(1, 1'b1, 8'h21, 32'hA1, 1);
        issue(2, 1'b0, 8'h22, 32'hA2, 1);
        issue(3, 1'b1, 8'h23, 32'hA3, 1);
        wait_drain("round_robin", 40);
        checks++;
        if (ready_cyc.size() != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d ready pulses required 5", ready_cyc.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (ready_cyc[i] - ready_cyc[i-1] != 3) begin
                    errors++;
                    $display("FAIL rr_spacing: grant %0d got %0d cycles required 3", i, ready_cyc[i] - ready_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        wait_states = 10;
        @(negedge clk_i);
        issue(3, 1'b0, 8'h33, 32'h0, 1);
        wait_mem_valid("reset_mid", 10);
        repeat (2) @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        clear_models();
        #1;
        checks++;
        if (mem_valid_o !== 1'b0 || state_o !== IDLE) begin
            errors++;
            $display("FAIL reset_async: got valid=%b state=%0d required 0/IDLE", mem_valid_o, state_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        wait_states = 0;
        @(negedge clk_i);
        push_exp(0, 1'b0, 8'h40, 32'h0, 1'b0);
        push_exp(1, 1'b0, 8'h41, 32'h0, 1'b0);
        issue(0, 1'b0, 8'h40, 32'h0, 1);
        issue(1, 1'b0, 8'h41, 32'h0, 1);
        wait_mem_valid("reset_regrant", 5);
        checks++;
        if (grant_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_regrant: got grant %0d required 0", grant_o);
        end
        wait_drain("reset_mid", 30);
    endtask

    task automatic test_wait_states();
        int n;
        wait_states = 5;
        @(negedge clk_i);
        push_exp(2, 1'b1, 8'h22, 32'h12345678, 1'b0);
        issue(2, 1'b1, 8'h22, 32'h12345678, 1);
        wait_mem_valid("wait_states", 5);
        n = 0;
        while (mem_valid_o && n < 20) begin
            checks++;
            if ({mem_wr_rd_o, mem_addr_o, mem_wdata_o} !== {1'b1, 8'h22, 32'h12345678}) begin
                errors++;
                $display("FAIL ws_stable: cycle %0d got %h required %h", n, {mem_wr_rd_o, mem_addr_o, mem_wdata_o}, {1'b1, 8'h22, 32'h12345678});
            end
            n++;
            @(negedge clk_i);
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL ws_length: got %0d valid cycles required 6", n);
        end
        wait_drain("wait_states", 20);
        checks++;
        if (req_rdata_o !== rdata_model) begin
            errors++;
            $display("FAIL ws_rdata_hold: got %h required %h", req_rdata_o, rdata_model);
        end
    endtask

    task automatic test_back_to_back();
        logic [NUM_REQ-1:0] mask;
        logic               wr[NUM_REQ];
        logic [AW-1:0]      a[NUM_REQ];
        logic [W-1:0]       d[NUM_REQ];
        int                 start;
        int                 idx;
        for (int r = 0; r < 15; r++) begin
            mask        = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            wait_states = $urandom_range(0, 3);
            @(negedge clk_i);
            for (int i = 0; i < NUM_REQ; i++) begin
                wr[i] = 1'($urandom_range(0, 1));
                a[i]  = AW'($urandom_range(0, 255));
                d[i]  = W'($urandom);
            end
            start = model_last;
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (start + k) % NUM_REQ;
                if (mask[idx]) push_exp(idx, wr[idx], a[idx], d[idx], 1'b0);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (mask[i]) issue(i, wr[i], a[i], d[i], 1);
            end
            wait_drain("back_to_back", 60);
        end
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        wait_states = 100;
        @(negedge clk_i);
        push_exp(1, 1'b0, 8'h55, 32'h0, 1'b1);
        issue(1, 1'b0, 8'h55, 32'h0, 1);
        wait_mem_valid("timeout", 5);
        n = 0;
        while (mem_valid_o && n < 40) begin
            n++;
            @(negedge clk_i);
        end
        checks++;
        if (n != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_length: got %0d access cycles required %0d", n, TIMEOUT);
        end
        wait_drain("timeout", 20);
    endtask

    task automatic test_timeout_tie();
        int n;
        wait_states = TIMEOUT - 1;
        @(negedge clk_i);
        push_exp(2, 1'b0, 8'h66, 32'h0, 1'b0);
        issue(2, 1'b0, 8'h66, 32'h0, 1);
        wait_mem_valid("timeout_tie", 5);
        n = 0;
        while (mem_valid_o && n < 40) begin
            n++;
            @(negedge clk_i);
        end
        checks++;
        if (n != TIMEOUT) begin
            errors++;
            $display("FAIL tie_length: got %0d access cycles required %0d", n, TIMEOUT);
        end
        wait_drain("timeout_tie", 20);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_reset_mid_access();
        test_wait_states();
        test_back_to_back();
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
        test_timeout_tie();
`endif
        repeat (3) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
